// File: rtl/relm_div_seq.sv
// Sequencer for the relm_custom divide unit: issues DIV, INIT, LOOPxk and MOD one op per cycle,
// owns the A and CB operand registers and returns quotient/remainder with a done pulse.
module relm_div_seq #(
    parameter int unsigned WD  = 32,
    parameter int unsigned WOP = 5,
    parameter int unsigned WC  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [WD-1:0]    n_in,
    input  logic [WD-1:0]    d_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WD-1:0]    q_out,
    output logic [WD-1:0]    r_out,
    output logic [WOP-1:0]   cu_op_out,
    output logic             cu_opb_out,
    output logic [WD-1:0]    cu_x_out,
    output logic [WD-1:0]    cu_xb_out,
    output logic [WD-1:0]    cu_a_out,
    output logic [WC+WD-1:0] cu_cb_out,
    input  logic [WD-1:0]    cu_a_in,
    input  logic [WC+WD-1:0] cu_cb_in
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StDiv   = 3'd1;
    localparam logic [2:0] StQcalc = 3'd2;
    localparam logic [2:0] StInit  = 3'd3;
    localparam logic [2:0] StLoop  = 3'd4;
    localparam logic [2:0] StMod   = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    localparam int unsigned MaxLoop = (WD + 1) / 2;
    localparam int unsigned LW      = $clog2(MaxLoop + 1);
    localparam int unsigned IW      = $clog2(WD);

    localparam logic [WOP-1:0] OpDiv  = WOP'(3'b101);
    localparam logic [WOP-1:0] OpNone = '0;

    localparam logic [1:0] SubInit = 2'b01;
    localparam logic [1:0] SubLoop = 2'b10;
    localparam logic [1:0] SubMod  = 2'b11;

    function automatic logic [WD-1:0] sub_x(input logic [1:0] sub);
        logic [WD-1:0] x;
        x = '0;
        x[WOP+1:WOP] = sub;
        return x;
    endfunction

    // Bit position of a one-hot value (Breg holds the one-hot MSB of D).
    function automatic logic [IW-1:0] onehot_index(input logic [WD-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WD; i++) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    logic [2:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WD-1:0]    q_q, q_d;
    logic [WD-1:0]    r_q, r_d;
    logic [WOP-1:0]   op_q, op_d;
    logic             opb_q, opb_d;
    logic [WD-1:0]    x_q, x_d;
    logic [WD-1:0]    xb_q, xb_d;
    logic [WD-1:0]    a_q, a_d;
    logic [WC+WD-1:0] cb_q, cb_d;
    logic [WD-1:0]    n_q, n_d;
    logic             dz_q, dz_d;
    logic [LW-1:0]    loop_q, loop_d;

    logic [WD-1:0]    breg;

    assign breg = cb_q[WD-1:0];

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        op_d    = op_q;
        opb_d   = opb_q;
        x_d     = x_q;
        xb_d    = xb_q;
        a_d     = a_q;
        cb_d    = cb_q;
        n_d     = n_q;
        dz_d    = dz_q;
        loop_d  = loop_q;

        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (start_in) begin
                    ready_d = 1'b0;
                    n_d     = n_in;
                    cb_d    = '0;
                    if (d_in == '0) begin
                        // Zero divisor resolves in QCALC without ever driving the unit.
                        dz_d    = 1'b1;
                        state_d = StQcalc;
                    end else begin
                        dz_d    = 1'b0;
                        op_d    = OpDiv;
                        opb_d   = 1'b0;
                        x_d     = '0;
                        xb_d    = d_in;
                        a_d     = n_in;
                        state_d = StDiv;
                    end
                end
            end

            StDiv: begin
                a_d     = cu_a_in;
                cb_d    = cu_cb_in;
                op_d    = OpNone;
                opb_d   = 1'b0;
                x_d     = '0;
                xb_d    = '0;
                state_d = StQcalc;
            end

            StQcalc: begin
                if (dz_q) begin
                    q_d     = '1;
                    r_d     = n_q;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (a_q < breg) begin
                    q_d     = '0;
                    r_d     = n_q;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    // Initial quotient step: 2^(msb(N) - msb(D)).
                    a_d     = a_q >> onehot_index(breg);
                    op_d    = OpDiv;
                    opb_d   = 1'b1;
                    x_d     = sub_x(SubInit);
                    state_d = StInit;
                end
            end

            StInit: begin
                a_d     = cu_a_in;
                cb_d    = cu_cb_in;
                x_d     = sub_x(SubLoop);
                loop_d  = '0;
                state_d = StLoop;
            end

            StLoop: begin
                a_d    = cu_a_in;
                cb_d   = cu_cb_in;
                loop_d = loop_q + LW'(1);
                if (cu_a_in == '0 || loop_q == LW'(MaxLoop - 1)) begin
                    x_d     = sub_x(SubMod);
                    state_d = StMod;
                end
            end

            StMod: begin
                q_d     = breg;
                r_d     = cu_a_in;
                done_d  = 1'b1;
                op_d    = OpNone;
                opb_d   = 1'b0;
                x_d     = '0;
                state_d = StDone;
            end

            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                ready_d = 1'b1;
                op_d    = OpNone;
                opb_d   = 1'b0;
                x_d     = '0;
                xb_d    = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            op_q    <= '0;
            opb_q   <= 1'b0;
            x_q     <= '0;
            xb_q    <= '0;
            a_q     <= '0;
            cb_q    <= '0;
            n_q     <= '0;
            dz_q    <= 1'b0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            x_q     <= x_d;
            xb_q    <= xb_d;
            a_q     <= a_d;
            cb_q    <= cb_d;
            n_q     <= n_d;
            dz_q    <= dz_d;
            loop_q  <= loop_d;
        end
    end

    assign ready_out  = ready_q;
    assign done_out   = done_q;
    assign q_out      = q_q;
    assign r_out      = r_q;
    assign cu_op_out  = op_q;
    assign cu_opb_out = opb_q;
    assign cu_x_out   = x_q;
    assign cu_xb_out  = xb_q;
    assign cu_a_out   = a_q;
    assign cu_cb_out  = cb_q;

endmodule

// File: tb/tb_relm_div_seq.sv
// Bench for relm_div_seq: behavioural model of the combinational divide unit, directed vectors,
// op trace, handshake, mid-operation reset and random operands against N/D, N%D.
`timescale 1ns/1ps
module tb_relm_div_seq;

    localparam int unsigned WD  = 32;
    localparam int unsigned WOP = 5;
    localparam int unsigned WC  = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_in;
    logic [WD-1:0]    n_in;
    logic [WD-1:0]    d_in;
    logic             ready_out;
    logic             done_out;
    logic [WD-1:0]    q_out;
    logic [WD-1:0]    r_out;
    logic [WOP-1:0]   cu_op_out;
    logic             cu_opb_out;
    logic [WD-1:0]    cu_x_out;
    logic [WD-1:0]    cu_xb_out;
    logic [WD-1:0]    cu_a_out;
    logic [WC+WD-1:0] cu_cb_out;
    logic [WD-1:0]    cu_a_in;
    logic [WC+WD-1:0] cu_cb_in;

    relm_div_seq #(
        .WD (WD),
        .WOP(WOP),
        .WC (WC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_in  (start_in),
        .n_in      (n_in),
        .d_in      (d_in),
        .ready_out (ready_out),
        .done_out  (done_out),
        .q_out     (q_out),
        .r_out     (r_out),
        .cu_op_out (cu_op_out),
        .cu_opb_out(cu_opb_out),
        .cu_x_out  (cu_x_out),
        .cu_xb_out (cu_xb_out),
        .cu_a_out  (cu_a_out),
        .cu_cb_out (cu_cb_out),
        .cu_a_in   (cu_a_in),
        .cu_cb_in  (cu_cb_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [WD-1:0] onehot_msb(input logic [WD-1:0] v);
        logic [WD-1:0] r;
        r = '0;
        for (int i = 0; i < WD; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int msb_idx(input logic [WD-1:0] v);
        int m;
        m = -1;
        for (int i = 0; i < WD; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

    function automatic int exp_loops(input logic [WD-1:0] n, input logic [WD-1:0] d);
        if (msb_idx(n) < msb_idx(d)) return 0;
        return (msb_idx(n) - msb_idx(d) + 2) / 2;
    endfunction

    // Unit model: Dreg = running remainder, Creg = D*step, Breg = Q, A = step; two bits per LOOP.
    logic [WD-1:0]   m_dreg, m_creg, m_breg, m_rem, m_q;
    logic [2*WD-1:0] m_prod;
    always_comb begin
        m_dreg   = cu_cb_out[WC+WD-1:2*WD];
        m_creg   = cu_cb_out[2*WD-1:WD];
        m_breg   = cu_cb_out[WD-1:0];
        m_rem    = m_dreg;
        m_q      = m_breg;
        m_prod   = '0;
        cu_a_in  = cu_a_out;
        cu_cb_in = cu_cb_out;
        if (cu_op_out[2:0] == 3'b101) begin
            if (!cu_opb_out) begin
                cu_a_in  = onehot_msb(cu_a_out);
                cu_cb_in = {cu_a_out, cu_xb_out, onehot_msb(cu_xb_out)};
            end else begin
                case (cu_x_out[WOP+1:WOP])
                    2'b01: begin
                        m_prod   = {{WD{1'b0}}, m_creg} * {{WD{1'b0}}, cu_a_out};
                        cu_cb_in = {m_dreg, m_prod[WD-1:0], {WD{1'b0}}};
                    end
                    2'b10: begin
                        if (m_creg <= m_rem) begin
                            m_rem = m_rem - m_creg;
                            m_q   = m_q + cu_a_out;
                        end
                        if (cu_a_out >= 2 && (m_creg >> 1) <= m_rem) begin
                            m_rem = m_rem - (m_creg >> 1);
                            m_q   = m_q + (cu_a_out >> 1);
                        end
                        cu_a_in  = cu_a_out >> 2;
                        cu_cb_in = {m_rem, m_creg >> 2, m_q};
                    end
                    2'b11: cu_a_in = m_dreg;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_loop_op();
        return cu_op_out[2:0] == 3'b101 && cu_opb_out && cu_x_out[WOP+1:WOP] == 2'b10;
    endfunction

    // Starts one request from IDLE, waits (bounded) for done, returns results and cycle counts.
    task automatic run_div(input logic [WD-1:0] n, input logic [WD-1:0] d,
                           output logic [WD-1:0] q, output logic [WD-1:0] r,
                           output int lat, output int loops, output int ops);
        n_in     = n;
        d_in     = d;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        lat   = 1;
        loops = 0;
        ops   = 0;
        while (!done_out && lat < 64) begin
            if (cu_op_out[2:0] == 3'b101) ops++;
            if (is_loop_op()) loops++;
            tick();
            lat++;
        end
        q = q_out;
        r = r_out;
        if (!done_out) begin
            check("timeout_done", {63'd0, done_out}, 64'd1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end else begin
            tick();
        end
    endtask

    typedef struct {
        logic [WD-1:0] n;
        logic [WD-1:0] d;
        logic [WD-1:0] q;
        logic [WD-1:0] r;
        int            lat;
        int            loops;
        int            ops;
    } vec_t;

    vec_t          vt [14];
    logic [9:0]    tr_exp [9];
    logic [WD-1:0] gq, gr, rn, rd, last_q, last_r;
    int            lat, loops, ops, el, nloop, acc, dn, ndone;
    logic          prev_done;
    logic [WD-1:0] eq_q [$];
    logic [WD-1:0] er_q [$];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,  8,  3,  6};
        vt[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  21, 16, 19};
        vt[2]  = '{32'd1000,       32'd10,         32'd100,        32'd0,  9,  4,  7};
        vt[3]  = '{32'd3,          32'd9,          32'd0,          32'd3,  3,  0,  1};
        vt[4]  = '{32'd55,         32'd0,          32'hFFFF_FFFF,  32'd55, 2,  0,  0};
        vt[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,  3,  0,  1};
        vt[6]  = '{32'd7,          32'd7,          32'd1,          32'd0,  6,  1,  4};
        vt[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  6,  1,  4};
        vt[8]  = '{32'd12,         32'd5,          32'd2,          32'd2,  6,  1,  4};
        vt[9]  = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,  21, 16, 19};
        vt[10] = '{32'd5,          32'd8,          32'd0,          32'd5,  3,  0,  1};
        vt[11] = '{32'd5,          32'd7,          32'd0,          32'd5,  6,  1,  4};
        vt[12] = '{32'd6,          32'd4,          32'd1,          32'd2,  6,  1,  4};
        vt[13] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,  2,  0,  0};

        // {op, opb, sub-op, done, ready} after each edge of a 100/7 request
        tr_exp[0] = 10'b00101_0_00_0_0;
        tr_exp[1] = 10'b00000_0_00_0_0;
        tr_exp[2] = 10'b00101_1_01_0_0;
        tr_exp[3] = 10'b00101_1_10_0_0;
        tr_exp[4] = 10'b00101_1_10_0_0;
        tr_exp[5] = 10'b00101_1_10_0_0;
        tr_exp[6] = 10'b00101_1_11_0_0;
        tr_exp[7] = 10'b00000_0_00_1_0;
        tr_exp[8] = 10'b00000_0_00_0_1;

        reset    = 1'b1;
        start_in = 1'b0;
        n_in     = '0;
        d_in     = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_ready", {63'd0, ready_out}, 64'd1);
        check("rst_done", {63'd0, done_out}, 64'd0);
        check("rst_q", q_out, 0);
        check("rst_r", r_out, 0);
        check("rst_op", {cu_op_out, cu_opb_out}, 0);
        check("rst_x_xb", {cu_x_out, cu_xb_out}, 0);
        check("rst_a", cu_a_out, 0);
        check("rst_cb", cu_cb_out[63:0], 0);
        check("rst_cb_hi", cu_cb_out[WC+WD-1:64], 0);

        // Cycle-by-cycle op trace of 100/7
        n_in     = 32'd100;
        d_in     = 32'd7;
        start_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            start_in = 1'b0;
            check($sformatf("trace%0d", i),
                  {cu_op_out, cu_opb_out, cu_x_out[WOP+1:WOP], done_out, ready_out}, tr_exp[i]);
            check($sformatf("trace%0d_xrest", i), cu_x_out & ~(32'h3 << WOP), 0);
            case (i)
                0: begin
                    check("div_xb", cu_xb_out, 7);
                    check("div_a", cu_a_out, 100);
                end
                2: check("qcalc_a", cu_a_out, 16);
                3: begin
                    check("init_creg", cu_cb_out[2*WD-1:WD], 112);
                    check("init_breg", cu_cb_out[WD-1:0], 0);
                    check("init_a", cu_a_out, 16);
                end
                4: check("loop1_q", cu_cb_out[WD-1:0], 8);
                5: check("loop2_q", cu_cb_out[WD-1:0], 14);
                6: check("loop3_q", cu_cb_out[WD-1:0], 14);
                7: begin
                    check("trace_q", q_out, 14);
                    check("trace_r", r_out, 2);
                end
                default: ;
            endcase
        end

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            check($sformatf("v%0d_ready", i), {63'd0, ready_out}, 64'd1);
            run_div(vt[i].n, vt[i].d, gq, gr, lat, loops, ops);
            check($sformatf("v%0d_q", i), gq, vt[i].q);
            check($sformatf("v%0d_r", i), gr, vt[i].r);
            check($sformatf("v%0d_lat", i), lat, vt[i].lat);
            check($sformatf("v%0d_loops", i), loops, vt[i].loops);
            check($sformatf("v%0d_ops", i), ops, vt[i].ops);
        end

        // start_in held high with changing operands
        acc       = 0;
        dn        = 0;
        prev_done = 1'b0;
        last_q    = q_out;
        last_r    = r_out;
        start_in  = 1'b1;
        n_in      = 32'd500;
        d_in      = 32'd3;
        for (int c = 0; c < 160; c++) begin
            if (start_in && ready_out) begin
                eq_q.push_back(n_in / d_in);
                er_q.push_back(n_in % d_in);
                acc++;
            end
            tick();
            if (prev_done) check("hs_ready_after_done", {63'd0, ready_out}, 64'd1);
            if (done_out) begin
                if (eq_q.size() == 0) begin
                    check("hs_spurious_done", {63'd0, done_out}, 64'd0);
                end else begin
                    check("hs_q", q_out, eq_q.pop_front());
                    check("hs_r", r_out, er_q.pop_front());
                    dn++;
                end
                last_q = q_out;
                last_r = r_out;
            end else begin
                check("hs_hold", {q_out, r_out}, {last_q, last_r});
            end
            prev_done = done_out;
            if (c < 120) begin
                n_in = $urandom;
                d_in = $urandom_range(1, 5000);
            end else begin
                start_in = 1'b0;
            end
        end
        check("hs_count", dn, acc);
        check("hs_accepted_some", {63'd0, acc >= 3}, 64'd1);
        check("hs_idle", {63'd0, ready_out}, 64'd1);

        // Reset during the second LOOP op
        n_in     = 32'd100;
        d_in     = 32'd7;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        nloop    = 0;
        for (int c = 0; c < 20 && nloop < 2; c++) begin
            tick();
            if (is_loop_op()) nloop++;
        end
        check("rl_reached_loop2", nloop, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rl_ready", {63'd0, ready_out}, 64'd1);
        check("rl_done", {63'd0, done_out}, 64'd0);
        check("rl_op", cu_op_out, 0);
        check("rl_q", q_out, 0);
        check("rl_r", r_out, 0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done_out) ndone++;
        end
        check("rl_no_done", ndone, 0);
        run_div(32'd100, 32'd7, gq, gr, lat, loops, ops);
        check("rl_after_q", gq, 14);
        check("rl_after_r", gr, 2);

        // Random operands against N/D, N%D
        for (int i = 0; i < 2000; i++) begin
            rn = $urandom;
            if (i % 4 == 0) rn = rn >> $urandom_range(0, 31);
            rd = $urandom >> $urandom_range(0, 31);
            if (rd == 0) rd = 1;
            run_div(rn, rd, gq, gr, lat, loops, ops);
            el = exp_loops(rn, rd);
            check("rnd_q", gq, rn / rd);
            check("rnd_r", gr, rn % rd);
            check("rnd_loops", loops, el);
            check("rnd_lat", lat, (msb_idx(rn) < msb_idx(rd)) ? 3 : 5 + el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
